dac_serial_tx: RTL
==================

Name: dac_serial_tx

Overview:
Upstream feeder for the 12-bit serial DAC stage. It accepts parallel samples, such as sine-table words, through a valid/ready handshake. Each sample is shifted out MSB-first on SI with SI_en framing the shift. It then issues a one-cycle soc so the downstream shift register's word is converted. Back-to-back operation with no idle cycles is supported, and an underrun pulse flags a missed sample.

Parameters:
N, 12, sample width in bits; also the number of SI_en cycles per frame
GAP, 0, idle cycles inserted after soc before the next frame may start (0..15)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
data_in  input  N  parallel sample to transmit
data_valid  input  1  data_in valid
data_ready  output  1  block can accept data_in this cycle
run  input  1  streaming mode; enables underrun detection
SI  output  1  serial data to DAC, MSB first
SI_en  output  1  high for exactly N cycles per frame while SI carries a bit
soc  output  1  one-cycle start-of-conversion, after the last bit
busy  output  1  frame in progress (SHIFT, SOC or GAP state)
underrun  output  1  one-cycle pulse: run high, frame ended, no sample available

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset (rst_n=0, asynchronous): state IDLE; shift register, bit counter and gap counter cleared.
- Output values in reset: SI=0, SI_en=0, soc=0, busy=0, underrun=0, data_ready=1.
- Reset mid-frame: the partial frame is discarded and no soc is issued.
- Registered outputs: SI, SI_en, soc, underrun and busy are all registered. data_ready is a combinational decode of state and counters.
- Handshake: a transfer happens on a rising edge where data_valid && data_ready. data_in is captured into the shift register; the block never drops or duplicates an accepted word.
- data_ready=1 in these cases only:
  - in IDLE;
  - in SOC when GAP==0;
  - in the last GAP cycle when GAP>0.
- State IDLE:
  - On a transfer: go to SHIFT, bit counter = N-1.
  - Otherwise: stay in IDLE; SI_en=0, soc=0.
- State SHIFT:
  - SI_en=1 and SI = shreg[N-1] each cycle; the shift register shifts left with 0 fill.
  - Counter decrements; after N cycles go to SOC.
- State SOC:
  - soc=1 and SI_en=0 for one cycle; SI=0.
  - GAP==0: a transfer in this cycle goes straight to SHIFT; otherwise go to IDLE.
  - GAP>0: go to GAP with gap counter = GAP-1.
- State GAP:
  - Outputs idle; counter decrements.
  - Last cycle: a transfer goes to SHIFT, otherwise go to IDLE.
- Latency: with the transfer on edge k, the MSB appears on SI with SI_en=1 in cycle k+1. The LSB appears in cycle k+N, and soc=1 in cycle k+N+1.
- Frame period: N+1+GAP cycles. With GAP=0 and data_valid held high, soc and SI_en are never high together, and SI_en is never low for more than one cycle between frames.
- Underrun: pulses for one cycle on the edge after the final frame cycle (the SOC or last GAP cycle) in which run=1 and no transfer occurred. It is never asserted in IDLE or when run=0.
- data_in is ignored whenever data_ready=0; data_valid may be held high throughout.
- SI is 0 whenever SI_en=0.

Test Plan:
- Reset values: assert rst_n=0 mid-SHIFT after 5 bits -> SI=SI_en=soc=busy=0 immediately, data_ready=1, no soc until a new transfer. After release, send 12'hABC -> full clean frame.
- Single word, N=12, GAP=0: send 12'hA5F -> SI_en high 12 cycles with SI=1,0,1,0,0,1,0,1,1,1,1,1, soc high 1 cycle after, then IDLE. Downstream SI_DAC pdata = 12'hA5F when soc is high.
- Back-to-back, GAP=0, data_valid held: send 12'h000, 12'hFFF, 12'h800 -> soc pulses exactly 13 cycles apart, with no SI_en/soc overlap.
- GAP=3: send two words continuously -> soc period = 16 cycles. data_ready high only in IDLE and in the last GAP cycle.
- Underrun: run=1, send one word then deassert data_valid -> underrun=1 for one cycle right after the soc cycle. Repeat with run=0 -> underrun stays 0.
- Handshake hold: data_valid=1 while busy, changing data_in each cycle -> only the value present at the data_ready cycle is transmitted.

Source files
------------

// File: rtl/dac_serial_tx.sv
// Serial feeder for a 12-bit DAC: takes parallel samples over valid/ready,
// shifts them out MSB-first on SI framed by SI_en, then pulses soc.
module dac_serial_tx #(
  parameter int unsigned N   = 12,
  parameter int unsigned GAP = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] data_in,
  input  logic         data_valid,
  output logic         data_ready,
  input  logic         run,
  output logic         SI,
  output logic         SI_en,
  output logic         soc,
  output logic         busy,
  output logic         underrun
);

  localparam int unsigned CNT_W = (N > 2) ? $clog2(N) : 1;
  localparam int unsigned GAP_W = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP) - GAP_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_SOC, S_GAP} state_t;

  state_t           state, state_d;
  logic [N-1:0]     shreg, shreg_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [GAP_W-1:0] gcnt, gcnt_d;
  logic             si_d, si_en_d, soc_d, busy_d, underrun_d;
  logic             xfer, frame_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      shreg    <= '0;
      cnt      <= '0;
      gcnt     <= '0;
      SI       <= 1'b0;
      SI_en    <= 1'b0;
      soc      <= 1'b0;
      busy     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      state    <= state_d;
      shreg    <= shreg_d;
      cnt      <= cnt_d;
      gcnt     <= gcnt_d;
      SI       <= si_d;
      SI_en    <= si_en_d;
      soc      <= soc_d;
      busy     <= busy_d;
      underrun <= underrun_d;
    end
  end

  // Outputs are computed from the next state so they line up with it after the edge.
  always_comb begin
    state_d    = state;
    shreg_d    = shreg;
    cnt_d      = cnt;
    gcnt_d     = gcnt;
    si_d       = 1'b0;
    si_en_d    = 1'b0;
    soc_d      = 1'b0;
    underrun_d = 1'b0;

    frame_end  = ((state == S_SOC) && (GAP == 0)) ||
                 ((state == S_GAP) && (gcnt == '0));
    data_ready = (state == S_IDLE) || frame_end;
    xfer       = data_valid && data_ready;

    case (state)
      S_SHIFT: begin
        if (cnt == '0) begin
          state_d = S_SOC;
          soc_d   = 1'b1;
        end else begin
          shreg_d = {shreg[N-2:0], 1'b0};
          cnt_d   = cnt - CNT_W'(1);
          si_d    = shreg[N-2];
          si_en_d = 1'b1;
        end
      end
      S_SOC: begin
        if (GAP != 0) begin
          state_d = S_GAP;
          gcnt_d  = GAP_LOAD;
        end
      end
      S_GAP: begin
        if (gcnt != '0) gcnt_d = gcnt - GAP_W'(1);
      end
      default: ;
    endcase

    // Frame ended with nothing to send: fall back to idle, flag a miss in streaming mode.
    if (frame_end && !xfer) begin
      state_d    = S_IDLE;
      underrun_d = run;
    end

    if (xfer) begin
      state_d = S_SHIFT;
      shreg_d = data_in;
      cnt_d   = CNT_LAST;
      si_d    = data_in[N-1];
      si_en_d = 1'b1;
    end

    busy_d = (state_d != S_IDLE);
  end

endmodule
